// File: rtl/pts_pkg.sv
// Shared types and sizing helpers for the parallel-to-serial shift register.
package pts_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } pts_state_t;

   localparam int unsigned MIN_BIT_WIDTH = 2;

   // Down-counter width; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w < MIN_BIT_WIDTH) ? 1 : 32'($clog2(w));
   endfunction

endpackage

// File: rtl/pts_nbit_if.sv
// Load handshake and serial output bundle between an upstream word source and pts_nbit.
interface pts_nbit_if #(
   parameter int unsigned BIT_WIDTH = 4
);
   logic [BIT_WIDTH-1:0] par_in;
   logic                 load_valid;
   logic                 load_ready;
   logic                 shift_enable;
   logic                 ser_out;
   logic                 busy;
   logic                 last_bit;

   modport master (
      output par_in, load_valid, shift_enable,
      input  load_ready, ser_out, busy, last_bit
   );

   modport slave (
      input  par_in, load_valid, shift_enable,
      output load_ready, ser_out, busy, last_bit
   );
endinterface

// File: rtl/pts_1bit.sv
// Single shift-register cell: parallel load beats shift beats hold.
module pts_1bit #(
   parameter bit IDLE_VAL = 1'b1
) (
   input  logic clk,
   input  logic n_rst,
   input  logic load,
   input  logic shift,
   input  logic par_bit,
   input  logic prev_bit,
   output logic q
);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)     q <= IDLE_VAL;
      else if (load)  q <= par_bit;
      else if (shift) q <= prev_bit;
   end

endmodule

// File: rtl/pts_nbit.sv
// Parallel-to-serial shift register with a valid/ready load port and gapless reload.
module pts_nbit
   import pts_pkg::*;
#(
   parameter int unsigned BIT_WIDTH = 4,
   parameter bit          MSB_FIRST = 1'b1,
   parameter bit          IDLE_VAL  = 1'b1
) (
   input  logic       clk,
   input  logic       n_rst,
   pts_nbit_if.slave  bus
);

   localparam int unsigned CNT_W = cnt_width(BIT_WIDTH);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIT_WIDTH - 1);

   pts_state_t           state, state_nxt;
   logic [CNT_W-1:0]     count, count_nxt;
   logic                 last_q, last_nxt;
   logic                 load_ready_c;
   logic                 load_c;
   logic                 shift_c;
   logic [BIT_WIDTH-1:0] q;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state  <= IDLE;
         count  <= '0;
         last_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         count  <= count_nxt;
         last_q <= last_nxt;
      end
   end

   // Final shift also fills the end cell with IDLE_VAL, so the output flop idles correctly.
   always_comb begin
      state_nxt    = state;
      count_nxt    = count;
      load_ready_c = 1'b0;
      load_c       = 1'b0;
      shift_c      = 1'b0;
      case (state)
         IDLE: begin
            load_ready_c = 1'b1;
            if (bus.load_valid) begin
               load_c    = 1'b1;
               count_nxt = CNT_LOAD;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (bus.shift_enable) begin
               if (count != '0) begin
                  shift_c   = 1'b1;
                  count_nxt = count - CNT_W'(1);
               end else begin
                  load_ready_c = 1'b1;
                  if (bus.load_valid) begin
                     load_c    = 1'b1;
                     count_nxt = CNT_LOAD;
                  end else begin
                     shift_c   = 1'b1;
                     state_nxt = IDLE;
                  end
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      last_nxt = (state_nxt == SHIFT) && (count_nxt == '0);
   end

   for (genvar i = 0; i < BIT_WIDTH; i++) begin : g_cell
      logic prev;
      if (MSB_FIRST) begin : g_msb
         if (i == 0) begin : g_end
            assign prev = IDLE_VAL;
         end else begin : g_mid
            assign prev = q[i-1];
         end
      end else begin : g_lsb
         if (i == BIT_WIDTH - 1) begin : g_end
            assign prev = IDLE_VAL;
         end else begin : g_mid
            assign prev = q[i+1];
         end
      end

      pts_1bit #(
         .IDLE_VAL (IDLE_VAL)
      ) u_cell (
         .clk      (clk),
         .n_rst    (n_rst),
         .load     (load_c),
         .shift    (shift_c),
         .par_bit  (bus.par_in[i]),
         .prev_bit (prev),
         .q        (q[i])
      );
   end

   if (MSB_FIRST) begin : g_out_msb
      assign bus.ser_out = q[BIT_WIDTH-1];
   end else begin : g_out_lsb
      assign bus.ser_out = q[0];
   end

   assign bus.load_ready = load_ready_c;
   assign bus.busy       = (state == SHIFT);
   assign bus.last_bit   = last_q;

endmodule

// File: tb/tb_pts_nbit.sv
// Directed bench for pts_nbit: MSB-first and LSB-first instances, hand-computed bit streams.
module tb_pts_nbit;

   logic clk     = 1'b0;
   logic clk_run = 1'b0;
   logic n_rst;
   int   vectors     = 0;
   int   miscompares = 0;

   pts_nbit_if #(.BIT_WIDTH(4)) bus_m ();
   pts_nbit_if #(.BIT_WIDTH(4)) bus_l ();

   pts_nbit #(.BIT_WIDTH(4), .MSB_FIRST(1'b1), .IDLE_VAL(1'b1)) dut_m (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus_m)
   );

   pts_nbit #(.BIT_WIDTH(4), .MSB_FIRST(1'b0), .IDLE_VAL(1'b1)) dut_l (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus_l)
   );

   always #5 if (clk_run) clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, " ser"},   8'(bus_m.ser_out),    8'd1);
      chk({tag, " busy"},  8'(bus_m.busy),       8'd0);
      chk({tag, " last"},  8'(bus_m.last_bit),   8'd0);
      chk({tag, " ready"}, 8'(bus_m.load_ready), 8'd1);
   endtask

   initial begin
      logic [3:0] word;
      logic [7:0] stream;
      logic       hs;

      n_rst              = 1'b1;
      bus_m.par_in       = '0;
      bus_m.load_valid   = 1'b0;
      bus_m.shift_enable = 1'b0;
      bus_l.par_in       = '0;
      bus_l.load_valid   = 1'b0;
      bus_l.shift_enable = 1'b0;

      // 1. reset without any clock edge, then shift_enable in IDLE
      #1 n_rst = 1'b0;
      #1;
      chk_idle("t1 rst");
      chk("t1 rst ser_l", 8'(bus_l.ser_out), 8'd1);
      clk_run = 1'b1;
      #1 n_rst = 1'b1;
      bus_m.shift_enable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_idle("t1 idle_shift");
      end

      // 2. 1010, shifting every cycle
      word = 4'b1010;
      bus_m.par_in     = word;
      bus_m.load_valid = 1'b1;
      tick();
      bus_m.load_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("t2 ser",  8'(bus_m.ser_out),  8'(word[3-i]));
         chk("t2 busy", 8'(bus_m.busy),     8'd1);
         chk("t2 last", 8'(bus_m.last_bit), 8'(i == 3));
         tick();
      end
      chk_idle("t2 end");

      // 3. 0110 with a three-cycle stall after the second bit
      word = 4'b0110;
      bus_m.par_in     = word;
      bus_m.load_valid = 1'b1;
      tick();
      bus_m.load_valid = 1'b0;
      chk("t3 b0", 8'(bus_m.ser_out), 8'd0);
      tick();
      chk("t3 b1", 8'(bus_m.ser_out), 8'd1);
      bus_m.shift_enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("t3 hold ready", 8'(bus_m.load_ready), 8'd0);
         tick();
         chk("t3 hold ser",  8'(bus_m.ser_out), 8'd1);
         chk("t3 hold busy", 8'(bus_m.busy),    8'd1);
      end
      bus_m.shift_enable = 1'b1;
      tick();
      chk("t3 b2", 8'(bus_m.ser_out), 8'd1);
      tick();
      chk("t3 b3",      8'(bus_m.ser_out),  8'd0);
      chk("t3 b3 last", 8'(bus_m.last_bit), 8'd1);
      tick();
      chk_idle("t3 end");

      // 4. back-to-back 1100 then 0011, second valid held until accepted
      stream = 8'b1100_0011;
      bus_m.par_in     = 4'b1100;
      bus_m.load_valid = 1'b1;
      tick();
      bus_m.par_in = 4'b0011;
      for (int i = 0; i < 8; i++) begin
         chk("t4 ser",  8'(bus_m.ser_out), 8'(stream[7-i]));
         chk("t4 busy", 8'(bus_m.busy),    8'd1);
         chk("t4 ready", 8'(bus_m.load_ready), 8'((i == 3) || (i == 7)));
         hs = bus_m.load_ready & bus_m.load_valid;
         tick();
         if (hs) bus_m.load_valid = 1'b0;
      end
      chk("t4 valid dropped", 8'(bus_m.load_valid), 8'd0);
      chk_idle("t4 end");

      // 5a. 1111 offered mid-word is ignored
      word = 4'b1010;
      bus_m.par_in     = word;
      bus_m.load_valid = 1'b1;
      tick();
      chk("t5 b0", 8'(bus_m.ser_out), 8'd1);
      bus_m.par_in     = 4'b1111;
      tick();
      bus_m.load_valid = 1'b0;
      chk("t5 b1", 8'(bus_m.ser_out), 8'd0);
      tick();
      chk("t5 b2", 8'(bus_m.ser_out), 8'd1);
      tick();
      chk("t5 b3", 8'(bus_m.ser_out), 8'd0);
      tick();
      chk_idle("t5 end");

      // 5b. LSB-first instance, 0001
      word = 4'b0001;
      bus_l.par_in       = word;
      bus_l.load_valid   = 1'b1;
      bus_l.shift_enable = 1'b1;
      tick();
      bus_l.load_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("t5l ser",  8'(bus_l.ser_out),  8'(word[i]));
         chk("t5l last", 8'(bus_l.last_bit), 8'(i == 3));
         tick();
      end
      chk("t5l idle ser",  8'(bus_l.ser_out), 8'd1);
      chk("t5l idle busy", 8'(bus_l.busy),    8'd0);

      // 6. reset mid-word, then 0101
      bus_m.par_in     = 4'b1010;
      bus_m.load_valid = 1'b1;
      tick();
      bus_m.load_valid = 1'b0;
      chk("t6 b0", 8'(bus_m.ser_out), 8'd1);
      tick();
      chk("t6 b1", 8'(bus_m.ser_out), 8'd0);
      #2 n_rst = 1'b0;
      #1;
      chk_idle("t6 rst");
      #1 n_rst = 1'b1;
      word = 4'b0101;
      bus_m.par_in     = word;
      bus_m.load_valid = 1'b1;
      tick();
      bus_m.load_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("t6 ser", 8'(bus_m.ser_out), 8'(word[3-i]));
         tick();
      end
      chk_idle("t6 end");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
